// File: rtl/a2d_intf_pkg.sv
// Shared types and constants for the ADC128S SPI front end: top FSM states,
// divider load value and command word layout.
package a2d_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TX1  = 2'd1,
      GAP  = 2'd2,
      TX2  = 2'd3
   } a2d_state_e;

   // Divider load: SCLK stays high for an 8-clk front porch before the first fall
   localparam logic [4:0] SCLK_LD = 5'b10111;

   localparam int CH_LSB = 11;
   localparam int CH_MSB = 13;

   function automatic logic [15:0] cmd_word(input logic [2:0] ch);
      logic [15:0] w;
      w = 16'h0000;
      w[CH_MSB:CH_LSB] = ch;
      return w;
   endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Bundle of the conversion request/result handshake and the ADC pins.
// master: the a2d_intf block; slave: control core plus ADC side.
interface a2d_intf_if;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        MISO;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic [11:0] res;
   logic [2:0]  res_ch;
   logic        cnv_cmplt;

   modport master (
      input  strt_cnv, chnnl, MISO,
      output SS_n, SCLK, MOSI, res, res_ch, cnv_cmplt
   );

   modport slave (
      output strt_cnv, chnnl, MISO,
      input  SS_n, SCLK, MOSI, res, res_ch, cnv_cmplt
   );
endinterface

// File: rtl/a2d_intf_spi_mnrch.sv
// Single 16-bit SPI master transaction: SCLK idle high, MISO sampled on the
// rising edge, data shifted on the falling edge (first fall does not shift).
module spi_mnrch
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] wt_data,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic        done,
   output logic [15:0] rd_data
);

   localparam logic [SCLK_DIV_W-1:0] DIV_LD   = (SCLK_DIV_W == 5) ? SCLK_DIV_W'(SCLK_LD)
                                                                  : ~SCLK_DIV_W'(32'd8);
   localparam logic [SCLK_DIV_W-1:0] DIV_FALL = {SCLK_DIV_W{1'b1}};
   localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

   logic [SCLK_DIV_W-1:0] sclk_div_r;
   logic [15:0]           shft_r;
   logic [3:0]            shft_cnt_r;
   logic                  ss_n_r;
   logic                  first_fall_r;
   logic                  miso_smp_r;
   logic                  fall_s;
   logic                  rise_s;
   logic                  last_s;
   logic                  launch_s;

   assign launch_s = wrt && ss_n_r;

   // Edge-imminent decode; last_s marks the 16th shift, where the fall is suppressed
   always_comb begin
      fall_s = 1'b0;
      rise_s = 1'b0;
      last_s = 1'b0;
      if (!ss_n_r) begin
         fall_s = (sclk_div_r == DIV_FALL);
         rise_s = (sclk_div_r == DIV_RISE);
         last_s = fall_s && !first_fall_r && (shft_cnt_r == 4'hF);
      end else begin
         fall_s = 1'b0;
         rise_s = 1'b0;
         last_s = 1'b0;
      end
   end

   // SCLK divider, slave select and first-fall flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_div_r   <= DIV_FALL;
         ss_n_r       <= 1'b1;
         first_fall_r <= 1'b0;
      end else if (launch_s) begin
         sclk_div_r   <= DIV_LD;
         ss_n_r       <= 1'b0;
         first_fall_r <= 1'b1;
      end else if (last_s) begin
         ss_n_r       <= 1'b1;
      end else if (!ss_n_r) begin
         sclk_div_r <= sclk_div_r + {{(SCLK_DIV_W-1){1'b0}}, 1'b1};
         if (fall_s) begin
            first_fall_r <= 1'b0;
         end
      end
   end

   // Shared tx/rx shift register and its shift counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shft_r     <= 16'h0000;
         shft_cnt_r <= 4'h0;
      end else if (launch_s) begin
         shft_r     <= wt_data;
         shft_cnt_r <= 4'h0;
      end else if (fall_s && !first_fall_r) begin
         shft_r     <= {shft_r[14:0], miso_smp_r};
         shft_cnt_r <= shft_cnt_r + 4'h1;
      end
   end

   // MISO captured just as SCLK rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso_smp_r <= 1'b0;
      end else if (rise_s) begin
         miso_smp_r <= MISO;
      end
   end

   assign SS_n    = ss_n_r;
   assign SCLK    = sclk_div_r[SCLK_DIV_W-1];
   assign MOSI    = shft_r[15];
   assign done    = last_s;
   // Presents the word as it will be after the final shift, so it is complete while done is high
   assign rd_data = {shft_r[14:0], miso_smp_r};

endmodule

// File: rtl/a2d_intf.sv
// ADC128S two-transaction conversion controller (channel select, then result).
// Build option A2D_ROUND_ROBIN_EN: channel comes from an internal pointer instead of chnnl.
module a2d_intf
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV_W = 5,
   parameter int GAP_CLKS   = 4
) (
   input logic         clk,
   input logic         rst_n,
   a2d_intf_if.master  bus
);

   localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

   a2d_state_e        state_r;
   a2d_state_e        state_nxt_s;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic [2:0]        ch_r;
   logic [2:0]        sel_ch_s;
   logic [11:0]       res_r;
   logic [2:0]        res_ch_r;
   logic              cnv_cmplt_r;
   logic              wrt_s;
   logic [15:0]       wt_data_s;
   logic              accept_s;
   logic              cmplt_s;
   logic              done_s;
   logic [15:0]       rd_data_s;
   logic              unused_rx_s;

   assign unused_rx_s = ^rd_data_s[15:12];

`ifdef A2D_ROUND_ROBIN_EN
   logic [2:0] rr_ptr_r;
   logic       unused_chnnl_s;

   assign unused_chnnl_s = ^bus.chnnl;
   assign sel_ch_s       = rr_ptr_r;

   // Channel pointer advances once per finished conversion, wrapping 7 -> 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= 3'd0;
      end else if (cmplt_s) begin
         rr_ptr_r <= rr_ptr_r + 3'd1;
      end
   end
`else
   assign sel_ch_s = bus.chnnl;
`endif

   spi_mnrch #(
      .SCLK_DIV_W (SCLK_DIV_W)
   ) u_spi (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (wrt_s),
      .wt_data (wt_data_s),
      .MISO    (bus.MISO),
      .SS_n    (bus.SS_n),
      .SCLK    (bus.SCLK),
      .MOSI    (bus.MOSI),
      .done    (done_s),
      .rd_data (rd_data_s)
   );

   // Top FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and transaction launch; strt_cnv outside IDLE is dropped
   always_comb begin
      state_nxt_s = state_r;
      wrt_s       = 1'b0;
      wt_data_s   = 16'h0000;
      accept_s    = 1'b0;
      cmplt_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.strt_cnv) begin
               accept_s    = 1'b1;
               wrt_s       = 1'b1;
               wt_data_s   = cmd_word(sel_ch_s);
               state_nxt_s = TX1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         TX1: begin
            if (done_s) begin
               state_nxt_s = GAP;
            end else begin
               state_nxt_s = TX1;
            end
         end
         GAP: begin
            if (gap_cnt_r == GAP_W'(GAP_CLKS - 1)) begin
               wrt_s       = 1'b1;
               state_nxt_s = TX2;
            end else begin
               state_nxt_s = GAP;
            end
         end
         TX2: begin
            if (done_s) begin
               cmplt_s     = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = TX2;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Gap counter runs only in GAP and sits at zero otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_r <= '0;
      end else if (state_r != GAP) begin
         gap_cnt_r <= '0;
      end else begin
         gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
      end
   end

   // Channel capture on accept; result, channel tag and valid flag on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_r        <= 3'd0;
         res_r       <= 12'h000;
         res_ch_r    <= 3'd0;
         cnv_cmplt_r <= 1'b0;
      end else if (accept_s) begin
         ch_r        <= sel_ch_s;
         cnv_cmplt_r <= 1'b0;
      end else if (cmplt_s) begin
         res_r       <= rd_data_s[11:0];
         res_ch_r    <= ch_r;
         cnv_cmplt_r <= 1'b1;
      end
   end

   assign bus.res       = res_r;
   assign bus.res_ch    = res_ch_r;
   assign bus.cnv_cmplt = cnv_cmplt_r;

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC128S and an SPI timing monitor.
module tb_a2d_intf;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   a2d_intf_if bus ();

   a2d_intf #(.SCLK_DIV_W(5), .GAP_CLKS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ADC model: channel addressed in one frame is converted in the next frame
   logic [11:0] analog [8] = '{12'hFFF, 12'h123, 12'h456, 12'h789,
                               12'h234, 12'hABC, 12'h5A5, 12'h000};
   logic [3:0]  adc_nib = 4'h0;
   logic [2:0]  adc_ch = 3'd0;
   logic [15:0] adc_sh = 16'h0000;
   int          adc_falls = 0;
   logic [15:0] mosi_sh = 16'h0000;
   logic [15:0] last_word = 16'h0000;
   logic [15:0] prev_word = 16'h0000;

   assign bus.MISO = adc_sh[15];

   always @(negedge bus.SS_n) begin
      adc_sh    <= {adc_nib, analog[adc_ch]};
      adc_falls <= 0;
      mosi_sh   <= 16'h0000;
   end

   always @(negedge bus.SCLK) begin
      if (bus.SS_n == 1'b0) begin
         if (adc_falls != 0) adc_sh <= {adc_sh[14:0], 1'b0};
         adc_falls <= adc_falls + 1;
      end
   end

   always @(posedge bus.SCLK) begin
      if (bus.SS_n == 1'b0) mosi_sh <= {mosi_sh[14:0], bus.MOSI};
   end

   always @(posedge bus.SS_n) begin
      prev_word <= last_word;
      last_word <= mosi_sh;
      adc_ch    <= mosi_sh[13:11];
   end

   // Timing monitor, sampled on the falling clk edge
   int   in_tx = 0, low_cnt = 0, high_cnt = 0, falls = 0, first_fall = -1, last_fall = 0, pbad = 0;
   int   tx_len = 0, tx_falls = 0, tx_first = -1, tx_pbad = 0, gap_len = 0, idle_bad = 0;
   logic sclk_q = 1'b1;

   always @(negedge clk) begin
      sclk_q <= bus.SCLK;
      if (bus.SS_n == 1'b0) begin
         if (in_tx == 0) begin
            in_tx <= 1; low_cnt <= 1; falls <= 0; first_fall <= -1; last_fall <= 0; pbad <= 0;
            gap_len <= high_cnt;
         end else begin
            low_cnt <= low_cnt + 1;
            if (bus.SCLK == 1'b0 && sclk_q == 1'b1) begin
               falls     <= falls + 1;
               last_fall <= low_cnt;
               if (falls == 0) first_fall <= low_cnt;
               else if (low_cnt - last_fall != 32) pbad <= 1;
            end
         end
      end else begin
         high_cnt <= (in_tx != 0) ? 1 : high_cnt + 1;
         if (in_tx != 0) begin
            in_tx <= 0; tx_len <= low_cnt; tx_falls <= falls; tx_first <= first_fall; tx_pbad <= pbad;
         end
         if (bus.SCLK == 1'b0) idle_bad <= 1;
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // strt_cnv high for one cycle; returns 1 ns after the accepting edge
   task automatic pulse_strt(input logic [2:0] ch);
      bus.strt_cnv = 1'b1;
      bus.chnnl    = ch;
      wait_edges(1);
      bus.strt_cnv = 1'b0;
   endtask

   task automatic test_reset();
      bus.strt_cnv = 1'b0;
      bus.chnnl    = 3'd0;
      rst_n        = 1'b0;
      wait_edges(3);
      n_tests++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL rst_ss_n: got %b want 1", bus.SS_n); end
      n_tests++; if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL rst_sclk: got %b want 1", bus.SCLK); end
      n_tests++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", bus.MOSI); end
      n_tests++; if (bus.res !== 12'h000) begin n_fail++; $display("FAIL rst_res: got %h want 000", bus.res); end
      n_tests++; if (bus.res_ch !== 3'd0) begin n_fail++; $display("FAIL rst_res_ch: got %0d want 0", bus.res_ch); end
      n_tests++; if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL rst_cmplt: got %b want 0", bus.cnv_cmplt); end
      rst_n = 1'b1;
      wait_edges(3);
   endtask

   task automatic test_conversion();
      adc_nib = 4'h0;
      pulse_strt(3'd5);
      n_tests++; if (bus.SS_n !== 1'b0) begin n_fail++; $display("FAIL conv_ss_fall: got %b want 0", bus.SS_n); end
      wait_edges(299);
      bus.strt_cnv = 1'b1;
      bus.chnnl    = 3'd2;
      wait_edges(1);
      bus.strt_cnv = 1'b0;
      wait_edges(745);
      n_tests++; if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL conv_early_cmplt: got %b want 0 at 1046", bus.cnv_cmplt); end
      wait_edges(1);
      n_tests++; if (bus.cnv_cmplt !== 1'b1) begin n_fail++; $display("FAIL conv_cmplt: got %b want 1 at 1047", bus.cnv_cmplt); end
      n_tests++; if (bus.res !== 12'hABC) begin n_fail++; $display("FAIL conv_res: got %h want abc", bus.res); end
      n_tests++; if (bus.res_ch !== 3'd5) begin n_fail++; $display("FAIL conv_res_ch: got %0d want 5", bus.res_ch); end
      n_tests++; if (prev_word !== 16'h2800) begin n_fail++; $display("FAIL conv_tx1_word: got %h want 2800", prev_word); end
      n_tests++; if (last_word !== 16'h0000) begin n_fail++; $display("FAIL conv_tx2_word: got %h want 0000", last_word); end
      wait_edges(53);
      n_tests++; if (tx_len !== 521) begin n_fail++; $display("FAIL ss_low_len: got %0d want 521", tx_len); end
      n_tests++; if (tx_falls !== 16) begin n_fail++; $display("FAIL sclk_falls: got %0d want 16", tx_falls); end
      n_tests++; if (tx_first !== 9) begin n_fail++; $display("FAIL first_fall: got %0d want 9", tx_first); end
      n_tests++; if (tx_pbad !== 0) begin n_fail++; $display("FAIL sclk_period: got %0d want 0 (period 32)", tx_pbad); end
      n_tests++; if (gap_len !== 4) begin n_fail++; $display("FAIL gap_len: got %0d want 4", gap_len); end
      n_tests++; if (idle_bad !== 0) begin n_fail++; $display("FAIL sclk_low_idle: got %0d want 0", idle_bad); end
      pulse_strt(3'd2);
      n_tests++; if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL ch2_clear: got %b want 0", bus.cnv_cmplt); end
      wait_edges(1046);
      n_tests++; if (bus.res !== 12'h456) begin n_fail++; $display("FAIL ch2_res: got %h want 456", bus.res); end
      n_tests++; if (bus.res_ch !== 3'd2) begin n_fail++; $display("FAIL ch2_res_ch: got %0d want 2", bus.res_ch); end
   endtask

   task automatic test_reset_mid();
      pulse_strt(3'd3);
      wait_edges(399);
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.SS_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ss_n: got %b want 1", bus.SS_n); end
      n_tests++; if (bus.SCLK !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sclk: got %b want 1", bus.SCLK); end
      n_tests++; if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cmplt: got %b want 0", bus.cnv_cmplt); end
      n_tests++; if (bus.res !== 12'h000) begin n_fail++; $display("FAIL mid_rst_res: got %h want 000", bus.res); end
      wait_edges(2);
      rst_n = 1'b1;
      wait_edges(2);
      pulse_strt(3'd4);
      wait_edges(1046);
      n_tests++; if (bus.res !== 12'h234) begin n_fail++; $display("FAIL post_rst_res: got %h want 234", bus.res); end
      n_tests++; if (bus.res_ch !== 3'd4) begin n_fail++; $display("FAIL post_rst_res_ch: got %0d want 4", bus.res_ch); end
      n_tests++; if (bus.cnv_cmplt !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmplt: got %b want 1", bus.cnv_cmplt); end
   endtask

   // ch0 then ch7 with a non-zero upper nibble from the ADC; second start lands on cycle 1047
   task automatic test_back_to_back();
      logic [2:0]  chs  [2] = '{3'd0, 3'd7};
      logic [11:0] exps [2] = '{12'hFFF, 12'h000};
      logic [15:0] cmds [2] = '{16'h0000, 16'h3800};
      adc_nib = 4'hF;
      for (int i = 0; i < 2; i++) begin
         pulse_strt(chs[i]);
         n_tests++; if (bus.cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL b2b_clear[%0d]: got %b want 0", i, bus.cnv_cmplt); end
         wait_edges(1046);
         n_tests++; if (bus.res !== exps[i]) begin n_fail++; $display("FAIL b2b_res[%0d]: got %h want %h", i, bus.res, exps[i]); end
         n_tests++; if (bus.res_ch !== chs[i]) begin n_fail++; $display("FAIL b2b_res_ch[%0d]: got %0d want %0d", i, bus.res_ch, chs[i]); end
         n_tests++; if (prev_word !== cmds[i]) begin n_fail++; $display("FAIL b2b_cmd[%0d]: got %h want %h", i, prev_word, cmds[i]); end
      end
      adc_nib = 4'h0;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_ch;
      for (int i = 0; i < 9; i++) begin
         exp_ch = 3'(i % 8);
         pulse_strt(3'd6);
         wait_edges(1046);
         n_tests++; if (bus.res_ch !== exp_ch) begin n_fail++; $display("FAIL rr_res_ch[%0d]: got %0d want %0d", i, bus.res_ch, exp_ch); end
         n_tests++; if (bus.res !== analog[exp_ch]) begin n_fail++; $display("FAIL rr_res[%0d]: got %h want %h", i, bus.res, analog[exp_ch]); end
         n_tests++; if (bus.cnv_cmplt !== 1'b1) begin n_fail++; $display("FAIL rr_cmplt[%0d]: got %b want 1", i, bus.cnv_cmplt); end
      end
   endtask

   initial begin
      test_reset();
`ifdef A2D_ROUND_ROBIN_EN
      test_round_robin();
`else
      test_conversion();
      test_reset_mid();
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
